// File: rtl/ni_pkg.sv
// ni_pkg: flit format, FSM state and field-width helpers shared by the NI injector.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif
package ni_pkg;
  typedef enum logic [1:0] {HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEADTAIL = 2'b11} flit_type_t;
  typedef enum logic [1:0] {ST_IDLE, ST_VCSEL, ST_HEAD, ST_BODY} state_t;
  localparam int FLIT_W = `FLIT_DATA_WIDTH;
  localparam int TYPE_LSB = FLIT_W - 2;
  function automatic int payload_w(int vc_bits);
    return TYPE_LSB - vc_bits;
  endfunction
endpackage

// File: rtl/ni_credit_counter.sv
// ni_credit_counter: credit count for one router VC, saturating at BUF_DEPTH with a sticky overflow flag.
module ni_credit_counter #(
  parameter int BUF_DEPTH = 4,
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          err
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= CW'(BUF_DEPTH);
      err   <= 1'b0;
    end else if (inc && !dec) begin
      if (count == CW'(BUF_DEPTH)) err <= 1'b1;
      else count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/ni_flit_injector.sv
// ni_flit_injector: segments core packets into flits and injects them into the router local port.
module ni_flit_injector
  import ni_pkg::*;
#(
  parameter int NUM_VC = 4,
  parameter int VC_BITS = $clog2(NUM_VC),
  parameter int BUF_DEPTH = 4,
  parameter int MAX_LEN = 8,
  parameter int LEN_BITS = $clog2(MAX_LEN + 1),
  parameter int DST_BITS = 4,
  localparam int PAYLOAD_W = payload_w(VC_BITS),
  localparam int CW = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic [DST_BITS-1:0]  pkt_dst,
  input  logic [LEN_BITS-1:0]  pkt_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [PAYLOAD_W-1:0] data_in,
  input  logic [NUM_VC-1:0]    credit_increment,
  output logic [FLIT_W-1:0]    out_data,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 credit_err
);
  state_t state, state_nx;
  flit_type_t ftype;
  logic [DST_BITS-1:0] dst;
  logic [LEN_BITS-1:0] remaining, len_eff;
  logic [VC_BITS-1:0] cur_vc, rr_ptr, sel_vc;
  logic [CW-1:0] credit [NUM_VC];
  logic [NUM_VC-1:0] err;
  logic found, emit, credit_ok, last;
  assign pkt_ready = reset && state == ST_IDLE;
  assign busy = state != ST_IDLE;
  assign credit_err = |err;
  assign credit_ok = credit[cur_vc] != '0;
  assign last = remaining == LEN_BITS'(1);
  assign len_eff = pkt_len == '0 ? LEN_BITS'(1) :
                   pkt_len > LEN_BITS'(MAX_LEN) ? LEN_BITS'(MAX_LEN) : pkt_len;
  // descending scan so the VC nearest the pointer wins
  always_comb begin
    found = 1'b0;
    sel_vc = '0;
    for (int i = NUM_VC - 1; i >= 0; i--)
      if (credit[VC_BITS'((int'(rr_ptr) + i) % NUM_VC)] != '0) begin
        found = 1'b1;
        sel_vc = VC_BITS'((int'(rr_ptr) + i) % NUM_VC);
      end
  end
  always_comb begin
    state_nx = state;
    emit = 1'b0;
    data_ready = 1'b0;
    ftype = HEAD;
    case (state)
      ST_IDLE: state_nx = pkt_valid && pkt_ready ? ST_VCSEL : ST_IDLE;
      ST_VCSEL: state_nx = found ? ST_HEAD : ST_VCSEL;
      ST_HEAD: begin
        emit = credit_ok;
        ftype = last ? HEADTAIL : HEAD;
        state_nx = !credit_ok ? ST_HEAD : last ? ST_IDLE : ST_BODY;
      end
      ST_BODY: begin
        emit = credit_ok && data_valid;
        data_ready = emit;
        ftype = last ? TAIL : BODY;
        state_nx = emit && last ? ST_IDLE : ST_BODY;
      end
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      dst <= '0;
      remaining <= '0;
      cur_vc <= '0;
      rr_ptr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      out_valid <= emit;
      if (emit) out_data <= {ftype, cur_vc, state == ST_HEAD ? PAYLOAD_W'(dst) : data_in};
      if (state == ST_IDLE && pkt_valid) begin
        dst <= pkt_dst;
        remaining <= len_eff;
      end
      if (state == ST_VCSEL && found) begin
        cur_vc <= sel_vc;
        rr_ptr <= sel_vc == VC_BITS'(NUM_VC - 1) ? '0 : sel_vc + 1'b1;
      end
      if (emit) remaining <= remaining - 1'b1;
    end
  end
  for (genvar g = 0; g < NUM_VC; g++) begin : g_cc
    ni_credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_cc (
      .clk(clk),
      .reset(reset),
      .dec(emit && cur_vc == VC_BITS'(g)),
      .inc(credit_increment[g]),
      .count(credit[g]),
      .err(err[g])
    );
  end
endmodule

// File: tb/tb_ni_flit_injector.sv
// tb_ni_flit_injector: random and directed stimulus checked against a packet-level reference model.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif
module tb_ni_flit_injector;
  localparam int NV = 4, VB = 2, BD = 4, ML = 8, LB = 4, DB = 4;
  localparam int FW = `FLIT_DATA_WIDTH, PW = FW - 2 - VB;
  logic clk = 1'b0, reset = 1'b0;
  logic pkt_valid = 1'b0, pkt_ready, data_valid = 1'b0, data_ready, out_valid, busy, credit_err;
  logic [DB-1:0] pkt_dst = '0;
  logic [LB-1:0] pkt_len = '0;
  logic [PW-1:0] data_in = '0;
  logic [NV-1:0] credit_increment = '0;
  logic [FW-1:0] out_data;
  ni_flit_injector dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_dst(pkt_dst), .pkt_len(pkt_len), .data_valid(data_valid), .data_ready(data_ready),
    .data_in(data_in), .credit_increment(credit_increment), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .credit_err(credit_err)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference model: one packet in flight, flits counted by how many have been sent
  int m_cred[NV], m_ptr, m_vc, m_len, m_sent;
  bit m_err, m_busy, m_sel, exp_ov;
  logic [DB-1:0] m_dst;
  logic [FW-1:0] exp_od;
  bit s_pv, s_dv;
  logic [DB-1:0] s_dst;
  logic [LB-1:0] s_len;
  logic [PW-1:0] s_data;
  logic [NV-1:0] s_inc;
  task automatic model_reset();
    foreach (m_cred[v]) m_cred[v] = BD;
    m_ptr = 0; m_err = 0; m_busy = 0; m_sel = 0; exp_ov = 0; exp_od = '0;
  endtask
  task automatic quiet();
    s_pv = 0; s_dv = 0; s_inc = '0; s_dst = '0; s_len = '0; s_data = '0;
  endtask
  task automatic step();
    bit emit, dr;
    int t, c;
    logic [PW-1:0] pl;
    @(negedge clk);
    pkt_valid = s_pv; pkt_dst = s_dst; pkt_len = s_len;
    data_valid = s_dv; data_in = s_data; credit_increment = s_inc;
    #1;
    emit = 0; dr = 0; t = 0; pl = '0;
    if (m_busy && m_sel && m_cred[m_vc] > 0) begin
      if (m_sent == 0) begin
        emit = 1; t = (m_len == 1) ? 3 : 0; pl = PW'(m_dst);
      end else if (s_dv) begin
        emit = 1; dr = 1; t = (m_sent == m_len - 1) ? 2 : 1; pl = s_data;
      end
    end
    chk("pkt_ready", pkt_ready, !m_busy);
    chk("data_ready", data_ready, dr);
    exp_ov = emit;
    if (emit) exp_od = {2'(t), VB'(m_vc), pl};
    if (!m_busy && s_pv) begin
      m_busy = 1; m_sel = 0; m_dst = s_dst; m_sent = 0;
      m_len = (s_len == 0) ? 1 : (s_len > ML) ? ML : int'(s_len);
    end else if (m_busy && !m_sel) begin
      for (int i = 0; i < NV && !m_sel; i++)
        if (m_cred[(m_ptr + i) % NV] > 0) begin
          m_sel = 1; m_vc = (m_ptr + i) % NV; m_ptr = (m_vc + 1) % NV;
        end
    end else if (emit) begin
      m_sent++;
      if (m_sent == m_len) m_busy = 0;
    end
    for (int v = 0; v < NV; v++) begin
      c = m_cred[v] - ((emit && v == m_vc) ? 1 : 0) + int'(s_inc[v]);
      if (c > BD) begin c = BD; m_err = 1; end
      m_cred[v] = c;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, exp_ov);
    chk("out_data", out_data, exp_od);
    chk("busy", busy, m_busy);
    chk("credit_err", credit_err, m_err);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_ready", pkt_ready, 0);
    chk("rst_credit_err", credit_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    quiet();
    do_reset();
    s_pv = 1; s_len = 1; s_dst = 4'h5;
    step();
    quiet();
    step();
    step();
    chk("t1_flit", out_data, 64'(32'hC000_0005));
    chk("t1_valid", out_valid, 1);
    repeat (2) step();
    s_pv = 1; s_len = 4; s_dst = 4'hA;
    step();
    quiet();
    s_dv = 1;
    repeat (8) begin s_data = PW'($urandom); step(); end
    quiet();
    s_inc = 4'b0100;
    step();
    chk("ovf_err", credit_err, 1);
    quiet();
    repeat (3) step();
    chk("ovf_sticky", credit_err, 1);
    do_reset();
    chk("ovf_cleared", credit_err, 0);
    s_pv = 1; s_len = 7; s_dst = 4'h3;
    step();
    quiet();
    s_dv = 1;
    repeat (8) begin s_data = PW'($urandom); step(); end
    chk("stall_busy", busy, 1);
    s_inc = 4'b0001; step(); s_inc = '0;
    repeat (3) begin s_data = PW'($urandom); step(); end
    chk("stall_busy2", busy, 1);
    s_inc = 4'b0001; step();
    s_data = PW'($urandom); step();
    s_inc = '0; s_data = PW'($urandom); step();
    quiet();
    repeat (2) step();
    chk("stall_done", busy, 0);
    do_reset();
    s_pv = 1; s_len = 5; s_dst = 4'h9;
    step();
    quiet();
    s_dv = 1;
    repeat (4) begin s_data = PW'($urandom); step(); end
    do_reset();
    quiet();
    repeat (4) step();
    chk("abort_ready", pkt_ready, 1);
    for (int p = 0; p < NV; p++) begin
      s_pv = 1; s_len = LB'(BD); s_dst = DB'(p);
      step();
      quiet();
      s_dv = 1;
      repeat (BD + 2) begin s_data = PW'($urandom); step(); end
    end
    for (int n = 0; n < 2000; n++) begin
      s_pv = $urandom_range(0, 2) == 0;
      s_len = LB'($urandom);
      s_dst = DB'($urandom);
      s_dv = $urandom_range(0, 3) != 0;
      s_data = PW'($urandom);
      for (int v = 0; v < NV; v++) s_inc[v] = m_cred[v] < BD && $urandom_range(0, 2) == 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
